// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, BTB entry layout and predictor FSM states.
// The tag field is sized for the smallest legal table; narrower tags are zero-extended.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int TAG_MAX_W = 28;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    word_t                target;
    logic [1:0]           ctr;
  } btb_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } bp_state_t;

  function automatic logic [TAG_MAX_W-1:0] pcTag(input word_t pc, input int idxW);
    word_t shifted;
    shifted = pc >> (idxW + 2);
    return shifted[TAG_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/sat_ctr2.sv
// Two-bit saturating up/down counter; purely combinational next-value logic.
module sat_ctr2 (
  input  logic [1:0] ctr,
  input  logic       up,
  output logic [1:0] nextCtr
);

  always_comb begin
    nextCtr = ctr;
    if (up && (ctr != 2'b11)) begin
      nextCtr = ctr + 2'b01;
    end else if (!up && (ctr != 2'b00)) begin
      nextCtr = ctr - 2'b01;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, a one-entry-per-cycle clear
// sweep and a saturating mispredict counter.
module branch_predictor
  import cpu_types_pkg::*;
#(
  parameter int         ENTRIES  = 16,
  parameter logic [1:0] CTR_INIT = 2'b10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] lkup_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        clr_req,
  output logic        busy,
  output logic [31:0] mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);

  btb_entry_t       btb [ENTRIES];
  bp_state_t        state, nextState;
  logic [IDX_W-1:0] sweepIdx, nextSweepIdx;
  logic [IDX_W-1:0] lkIdx, upIdx;
  btb_entry_t       lkEntry, upEntry;
  logic             upHit, upPredTaken, updEn, mispredict;
  logic [1:0]       upNextCtr;

  assign lkIdx   = lkup_pc[IDX_W+1:2];
  assign lkEntry = btb[lkIdx];
  assign busy    = (state == CLEAR);

  assign pred_hit    = !busy && lkEntry.valid && (lkEntry.tag == pcTag(lkup_pc, IDX_W));
  assign pred_taken  = pred_hit && lkEntry.ctr[1];
  assign pred_target = pred_taken ? lkEntry.target : 32'h0;

  assign upIdx       = upd_pc[IDX_W+1:2];
  assign upEntry     = btb[upIdx];
  assign upHit       = upEntry.valid && (upEntry.tag == pcTag(upd_pc, IDX_W));
  assign upPredTaken = upHit && upEntry.ctr[1];

  // A clear request in the same cycle as an update takes priority and drops it.
  assign updEn      = (state == IDLE) && upd_valid && !clr_req;
  assign mispredict = updEn && ((upPredTaken != upd_taken) ||
                      (upPredTaken && upd_taken && (upEntry.target != upd_target)));

  sat_ctr2 uCtr (
    .ctr    (upEntry.ctr),
    .up     (upd_taken),
    .nextCtr(upNextCtr)
  );

  always_comb begin
    nextState    = state;
    nextSweepIdx = sweepIdx;
    case (state)
      IDLE: begin
        if (clr_req) begin
          nextState    = CLEAR;
          nextSweepIdx = '0;
        end
      end
      CLEAR: begin
        nextSweepIdx = sweepIdx + 1'b1;
        if (sweepIdx == IDX_W'(ENTRIES - 1)) begin
          nextState    = IDLE;
          nextSweepIdx = '0;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      sweepIdx <= '0;
    end else begin
      state    <= nextState;
      sweepIdx <= nextSweepIdx;
    end
  end

  // Only valid bits are reset; tag, target and counter are don't-care while invalid.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb[i].valid <= 1'b0;
      end
    end else if (busy) begin
      btb[sweepIdx].valid <= 1'b0;
    end else if (updEn) begin
      if (upHit) begin
        btb[upIdx].ctr <= upNextCtr;
        if (upd_taken) begin
          btb[upIdx].target <= upd_target;
        end
      end else if (upd_taken) begin
        btb[upIdx] <= '{valid: 1'b1, tag: pcTag(upd_pc, IDX_W),
                        target: upd_target, ctr: CTR_INIT};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mispred_cnt <= '0;
    end else if (mispredict && (mispred_cnt != 32'hFFFF_FFFF)) begin
      mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

endmodule
